// File: rtl/mux_eight_pkg.sv
// Shared types and constants for the registered 8:1 mux with one-hot positioned output.
package mux_eight_pkg;

    localparam int SEL_W = 3;
    localparam int N_IN  = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_IN-1:0]  vec_t;

    localparam vec_t RESULT_RST = 8'h00;

endpackage : mux_eight_pkg

// File: rtl/mux_eight_dec.sv
// Combinational select stage: picks data[s] and places it at bit s of an otherwise-zero vector.
module mux_eight_dec
    import mux_eight_pkg::*;
(
    input  logic [2:0] s,
    input  logic [7:0] data,
    output logic       mux_val,
    output logic [7:0] pos_vec
);

    assign mux_val = data[s];

    // Each bit only passes its own input when selected, so at most one bit can be set.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_pos
            assign pos_vec[gi] = (s == sel_t'(gi)) & data[gi];
        end
    endgenerate

endmodule : mux_eight_dec

// File: rtl/mux_eight.sv
// Registered 8:1 mux: one-cycle latency to y, the positioned vector result, and the select copy sel_q.
module mux_eight
    import mux_eight_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] s,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       I4,
    input  logic       I5,
    input  logic       I6,
    input  logic       I7,
    output logic [7:0] result,
    output logic       y,
    output logic [2:0] sel_q
);

    vec_t data_in;
    logic mux_next;
    vec_t result_next;

    vec_t result_reg;
    logic y_reg;
    sel_t sel_reg;

    assign data_in = {I7, I6, I5, I4, I3, I2, I1, I0};

    mux_eight_dec u_dec (
        .s       (s),
        .data    (data_in),
        .mux_val (mux_next),
        .pos_vec (result_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= RESULT_RST;
            y_reg      <= 1'b0;
            sel_reg    <= '0;
        end else begin
            result_reg <= result_next;
            y_reg      <= mux_next;
            sel_reg    <= s;
        end
    end

    assign result = result_reg;
    assign y      = y_reg;
    assign sel_q  = sel_reg;

endmodule : mux_eight

// File: tb/tb_mux_eight.sv
// Directed-vector bench for mux_eight with hand-computed expected outputs.
module tb_mux_eight;

    logic       clk;
    logic       rst_n;
    logic [2:0] s;
    logic [7:0] i_vec;
    logic [7:0] result;
    logic       y;
    logic [2:0] sel_q;

    int checks = 0;
    int errors = 0;

    mux_eight dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (s),
        .I0     (i_vec[0]),
        .I1     (i_vec[1]),
        .I2     (i_vec[2]),
        .I3     (i_vec[3]),
        .I4     (i_vec[4]),
        .I5     (i_vec[5]),
        .I6     (i_vec[6]),
        .I7     (i_vec[7]),
        .result (result),
        .y      (y),
        .sel_q  (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] exp_res, input logic exp_y,
                              input logic [2:0] exp_sel);
        check_val({tag, ".result"}, result, exp_res);
        check_val({tag, ".y"}, {7'd0, y}, {7'd0, exp_y});
        check_val({tag, ".sel_q"}, {5'd0, sel_q}, {5'd0, exp_sel});
    endtask

    // Drive one select/data set, let one edge capture it, then check just after the edge.
    task automatic apply(input string tag, input logic [2:0] sv, input logic [7:0] dv,
                         input logic [7:0] exp_res, input logic exp_y);
        s     = sv;
        i_vec = dv;
        @(posedge clk);
        #1;
        $display("tx %s s=%0d data=%h -> result=%h y=%b sel_q=%0d", tag, sv, dv, result, y, sel_q);
        check_outs(tag, exp_res, exp_y, sv);
    endtask

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] iso_exp   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
    logic       iso_y     [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        s     = 3'd7;
        i_vec = 8'hFF;

        // Reset held with all inputs at 1: outputs stay cleared across edges.
        #1;
        check_outs("reset_t0", 8'h00, 1'b0, 3'd0);
        @(posedge clk); #1;
        check_outs("reset_e1", 8'h00, 1'b0, 3'd0);
        @(posedge clk); #1;
        check_outs("reset_e2", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            apply($sformatf("sweep%0d", k), 3'(k), 8'hFF, sweep_exp[k], 1'b1);

        for (int k = 0; k < 8; k++)
            apply($sformatf("zero%0d", k), 3'(k), 8'h00, 8'h00, 1'b0);

        for (int k = 0; k < 8; k++)
            apply($sformatf("iso%0d", k), 3'(k), 8'h20, iso_exp[k], iso_y[k]);

        apply("wrap7", 3'd7, 8'hFF, 8'h80, 1'b1);
        apply("wrap0", 3'd0, 8'hFF, 8'h01, 1'b1);

        // Select and data change together: new select must see new data.
        apply("simul3", 3'd3, 8'h08, 8'h08, 1'b1);
        apply("simul6", 3'd6, 8'h40, 8'h40, 1'b1);
        apply("simul1", 3'd1, 8'hFD, 8'h00, 1'b0);

        // Mid-run reset between edges while result = 8'h10.
        apply("pre_rst", 3'd4, 8'hFF, 8'h10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midrst_now", 8'h00, 1'b0, 3'd0);
        @(posedge clk); #1;
        check_outs("midrst_hold", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;
        apply("post_rst", 3'd2, 8'hFF, 8'h04, 1'b1);
        apply("post_rst2", 3'd5, 8'h20, 8'h20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux_eight
